// File: rtl/pipe_pkg.sv
// Shared types and default vectors for the pipelined datapath.
// Used by the fetch-stage program-counter unit.
package pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  localparam logic [15:0] RESET_VEC_D = 16'h0000;
  localparam logic [15:0] TRAP_VEC_D  = 16'h0100;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect priority and alignment check for the PC unit.
// A fresh branch beats a fresh jump; a fresh redirect beats a buffered one.
module pc_redirect_sel #(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_taken,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             pend_vld,
  input  logic             pend_br,
  input  logic [WIDTH-1:0] pend_tgt,
  output logic             new_vld,
  output logic             new_is_br,
  output logic [WIDTH-1:0] new_tgt,
  output logic             capture,
  output logic             load_vld,
  output logic [WIDTH-1:0] load_tgt,
  output logic             load_misalign
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(STEP - 1);

  assign new_vld   = br_taken | jmp_taken;
  assign new_is_br = br_taken;
  assign new_tgt   = br_taken ? br_target : jmp_target;

  // A younger jump must not displace a branch already waiting out a stall.
  assign capture = new_vld && !(pend_vld && pend_br && !br_taken);

  assign load_vld      = new_vld | pend_vld;
  assign load_tgt      = new_vld ? new_tgt : pend_tgt;
  assign load_misalign = load_vld && ((load_tgt & MASK) != '0);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects, a one-entry
// pending-redirect buffer for stalls, and a halt/resume state machine.
module pc_unit
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_D),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(TRAP_VEC_D)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             trap,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_taken,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_prev,
  output logic [WIDTH-1:0] pc_seq,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign
);

  pc_state_t        state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] pc_prev_reg, pc_prev_next;
  logic             pend_vld_reg, pend_vld_next;
  logic             pend_br_reg, pend_br_next;
  logic [WIDTH-1:0] pend_tgt_reg, pend_tgt_next;
  logic             misalign_reg, misalign_next;
  logic             started_reg, started_next;

  logic             new_vld;
  logic             new_is_br;
  logic [WIDTH-1:0] new_tgt;
  logic             capture;
  logic             load_vld;
  logic [WIDTH-1:0] load_tgt;
  logic             load_misalign;

  pc_redirect_sel #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_sel (
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_taken    (jmp_taken),
    .jmp_target   (jmp_target),
    .pend_vld     (pend_vld_reg),
    .pend_br      (pend_br_reg),
    .pend_tgt     (pend_tgt_reg),
    .new_vld      (new_vld),
    .new_is_br    (new_is_br),
    .new_tgt      (new_tgt),
    .capture      (capture),
    .load_vld     (load_vld),
    .load_tgt     (load_tgt),
    .load_misalign(load_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_VEC;
      pc_prev_reg  <= RESET_VEC;
      pend_vld_reg <= 1'b0;
      pend_br_reg  <= 1'b0;
      pend_tgt_reg <= '0;
      misalign_reg <= 1'b0;
      started_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_prev_reg  <= pc_prev_next;
      pend_vld_reg <= pend_vld_next;
      pend_br_reg  <= pend_br_next;
      pend_tgt_reg <= pend_tgt_next;
      misalign_reg <= misalign_next;
      started_reg  <= started_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pend_vld_next = pend_vld_reg;
    pend_br_next  = pend_br_reg;
    pend_tgt_next = pend_tgt_reg;
    misalign_next = misalign_reg;
    started_next  = started_reg;

    // The first edge after reset only arms fetch; the PC stays at the vector.
    if (!started_reg) begin
      started_next = 1'b1;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (trap) begin
            pc_next       = TRAP_VEC;
            pend_vld_next = 1'b0;
          end else if (halt_req) begin
            state_next = HALTED;
          end else if (stall) begin
            if (capture) begin
              pend_vld_next = 1'b1;
              pend_br_next  = new_is_br;
              pend_tgt_next = new_tgt;
            end
          end else if (load_vld) begin
            pend_vld_next = 1'b0;
            if (load_misalign) begin
              pc_next       = TRAP_VEC;
              misalign_next = 1'b1;
            end else begin
              pc_next = load_tgt;
            end
          end else begin
            pc_next = pc_reg + WIDTH'(STEP);
          end
        end
        HALTED: begin
          if (trap) begin
            pc_next       = TRAP_VEC;
            state_next    = RUN;
            pend_vld_next = 1'b0;
          end else if (resume) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end

    pc_prev_next = (pc_next != pc_reg) ? pc_reg : pc_prev_reg;
  end

  assign pc       = pc_reg;
  assign pc_prev  = pc_prev_reg;
  assign pc_seq   = pc_reg + WIDTH'(STEP);
  assign pc_valid = started_reg && (state_reg == RUN);
  assign halted   = (state_reg == HALTED);
  assign misalign = misalign_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed expectations,
// the monitor pops and compares them on the falling edge or on demand.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        trap = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0;
  logic        jmp_taken = 1'b0;
  logic [15:0] jmp_target = 16'h0;
  logic [15:0] pc, pc_prev, pc_seq;
  logic        pc_valid, halted, misalign;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic [15:0] prev;
    logic        v;
    logic        h;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  event chk_ev;

  pc_unit #(
    .WIDTH    (16),
    .STEP     (2),
    .RESET_VEC(16'h0000),
    .TRAP_VEC (16'h0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .halt_req  (halt_req),
    .resume    (resume),
    .trap      (trap),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp_taken (jmp_taken),
    .jmp_target(jmp_target),
    .pc        (pc),
    .pc_prev   (pc_prev),
    .pc_seq    (pc_seq),
    .pc_valid  (pc_valid),
    .halted    (halted),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  // Monitor: every queued expectation is checked against the live outputs.
  always begin
    @(negedge clk or chk_ev);
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] seq_exp;
      e = q.pop_front();
      seq_exp = e.pc + 16'd2;
      total++;
      if (pc !== e.pc || pc_prev !== e.prev || pc_seq !== seq_exp ||
          pc_valid !== e.v || halted !== e.h || misalign !== e.m) begin
        bad++;
        $display("FAIL %s: got pc=%h prev=%h seq=%h v=%b h=%b m=%b want pc=%h prev=%h seq=%h v=%b h=%b m=%b",
                 e.nm, pc, pc_prev, pc_seq, pc_valid, halted, misalign,
                 e.pc, e.prev, seq_exp, e.v, e.h, e.m);
      end else begin
        $display("chk %s: pc=%h prev=%h v=%b h=%b m=%b", e.nm, pc, pc_prev, pc_valid, halted, misalign);
      end
    end
  end

  task automatic cyc(input string nm, input logic [15:0] epc, input logic [15:0] eprev,
                     input logic ev, input logic eh, input logic em);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm = nm; e.pc = epc; e.prev = eprev; e.v = ev; e.h = eh; e.m = em;
    q.push_back(e);
  endtask

  task automatic chk_now(input string nm, input logic [15:0] epc, input logic [15:0] eprev,
                         input logic ev, input logic eh, input logic em);
    exp_t e;
    e.nm = nm; e.pc = epc; e.prev = eprev; e.v = ev; e.h = eh; e.m = em;
    q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    #12;
    chk_now("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Idle run: first edge only raises pc_valid.
    cyc("idle_e1", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc("idle_e2", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc("idle_e3", 16'h0004, 16'h0002, 1'b1, 1'b0, 1'b0);
    cyc("idle_e4", 16'h0006, 16'h0004, 1'b1, 1'b0, 1'b0);

    // Halt at 0x0006; branches and stalls are ignored while halted.
    halt_req = 1'b1;
    cyc("halt", 16'h0006, 16'h0004, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b0;
    br_taken = 1'b1; br_target = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      halt_req = (i == 2);
      cyc("halt_hold", 16'h0006, 16'h0004, 1'b0, 1'b1, 1'b0);
    end
    br_taken = 1'b0; stall = 1'b0; halt_req = 1'b0;
    resume = 1'b1;
    cyc("resume", 16'h0006, 16'h0004, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    cyc("resume_seq", 16'h0008, 16'h0006, 1'b1, 1'b0, 1'b0);
    cyc("to_0a", 16'h000A, 16'h0008, 1'b1, 1'b0, 1'b0);
    cyc("to_0c", 16'h000C, 16'h000A, 1'b1, 1'b0, 1'b0);
    cyc("to_0e", 16'h000E, 16'h000C, 1'b1, 1'b0, 1'b0);
    cyc("to_10", 16'h0010, 16'h000E, 1'b1, 1'b0, 1'b0);

    // Branch during stall is buffered and applied on release.
    stall = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
    cyc("stall_br", 16'h0010, 16'h000E, 1'b1, 1'b0, 1'b0);
    br_taken = 1'b0;
    cyc("stall_2", 16'h0010, 16'h000E, 1'b1, 1'b0, 1'b0);
    cyc("stall_3", 16'h0010, 16'h000E, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    cyc("pend_load", 16'h0040, 16'h0010, 1'b1, 1'b0, 1'b0);
    cyc("pend_clr", 16'h0042, 16'h0040, 1'b1, 1'b0, 1'b0);

    // Branch beats jump; misaligned jump traps and sets misalign.
    br_taken = 1'b1; br_target = 16'h0080; jmp_taken = 1'b1; jmp_target = 16'h0020;
    cyc("br_over_jmp", 16'h0080, 16'h0042, 1'b1, 1'b0, 1'b0);
    br_taken = 1'b0; jmp_target = 16'h0021;
    cyc("misalign_jmp", 16'h0100, 16'h0080, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0;
    cyc("sticky_mis", 16'h0102, 16'h0100, 1'b1, 1'b0, 1'b1);

    // Trap while halted and stalled discards the pending branch.
    stall = 1'b1; br_taken = 1'b1; br_target = 16'h0200;
    cyc("stall_pend", 16'h0102, 16'h0100, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b0; halt_req = 1'b1;
    cyc("halt_stall", 16'h0102, 16'h0100, 1'b0, 1'b1, 1'b1);
    halt_req = 1'b0; trap = 1'b1;
    cyc("trap_halted", 16'h0100, 16'h0102, 1'b1, 1'b0, 1'b1);
    trap = 1'b0; stall = 1'b0;
    cyc("no_pend", 16'h0102, 16'h0100, 1'b1, 1'b0, 1'b1);

    // Wrap at the top of the address space.
    jmp_taken = 1'b1; jmp_target = 16'hFFFE;
    cyc("jmp_fffe", 16'hFFFE, 16'h0102, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0;
    cyc("wrap", 16'h0000, 16'hFFFE, 1'b1, 1'b0, 1'b1);
    cyc("after_wrap", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);

    // A later jump must not replace a buffered branch.
    stall = 1'b1; br_taken = 1'b1; br_target = 16'h0300;
    cyc("pend_br", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b0; jmp_taken = 1'b1; jmp_target = 16'h0400;
    cyc("jmp_kept_out", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    jmp_taken = 1'b0; stall = 1'b0;
    cyc("br_wins", 16'h0300, 16'h0002, 1'b1, 1'b0, 1'b1);

    // Trap in RUN overrides stall and halt_req.
    stall = 1'b1; halt_req = 1'b1; trap = 1'b1;
    cyc("trap_run", 16'h0100, 16'h0300, 1'b1, 1'b0, 1'b1);
    halt_req = 1'b0; trap = 1'b0;

    // Asynchronous reset mid-stall with a pending branch.
    br_taken = 1'b1; br_target = 16'h0500;
    cyc("pend_500", 16'h0100, 16'h0300, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_now("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc("rst_held", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; stall = 1'b0;
    cyc("rel_e1", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc("rel_e2", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc("rel_e3", 16'h0004, 16'h0002, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
